cdb_arbiter: RTL and testbench

- Transmit side of the common data bus (CDB).
- Collects completed results from the functional units (ALU, mult, mem, branch), buffers them in one small FIFO per unit, and picks one per cycle with round-robin arbitration.
- Drives the registered single-lane broadcast (cdb_valid/cdb_tag/value/rob_idx) consumed by RS tag-match wakeup, PRF write and ROB completion.
- Applies per-unit backpressure through fu_ready.

---
 rtl/cdb_arbiter_if.sv | 30 +++
 rtl/cdb_arbiter.sv | 119 +++++++++++
 tb/tb_cdb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result sources and the single-lane CDB broadcast.
// Every field is packed per source: source i sits at [i*W +: W].
interface cdb_arbiter_if #(
    parameter int NUM_FU  = 4,
    parameter int FU_IDX  = 2,
    parameter int PRF_IDX = 6,
    parameter int ROB_IDX = 5
) ();
    logic [NUM_FU-1:0]         fu_valid;
    logic [NUM_FU*PRF_IDX-1:0] fu_tag;
    logic [NUM_FU*64-1:0]      fu_value;
    logic [NUM_FU*ROB_IDX-1:0] fu_rob_idx;
    logic [NUM_FU-1:0]         fu_ready;
    logic                      flush;
    logic                      cdb_valid;
    logic [PRF_IDX-1:0]        cdb_tag;
    logic [63:0]               cdb_value;
    logic [ROB_IDX-1:0]        cdb_rob_idx;
    logic [FU_IDX-1:0]         cdb_src;

    modport master (
        output fu_valid, fu_tag, fu_value, fu_rob_idx, flush,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_idx, cdb_src
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value, fu_rob_idx, flush,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_idx, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB transmit side: one small FIFO per functional unit, a round-robin pick
// of one head per cycle, and a registered broadcast that never stalls.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int FU_IDX     = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int PRF_IDX    = 6,
    parameter int ROB_IDX    = 5
) (
    input  logic         clk,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [PRF_IDX-1:0] tag;
        logic [63:0]        value;
        logic [ROB_IDX-1:0] rob_idx;
    } entry_t;

    entry_t [NUM_FU-1:0] w_head;
    logic [NUM_FU-1:0]   w_nonempty;
    logic [NUM_FU-1:0]   w_ready;
    logic [NUM_FU-1:0]   w_push;
    logic [NUM_FU-1:0]   w_pop;
    logic                w_grant;
    logic [FU_IDX-1:0]   w_winner;

    logic [FU_IDX-1:0]   r_rr_ptr;
    logic                r_cdb_valid;
    logic [PRF_IDX-1:0]  r_cdb_tag;
    logic [63:0]         r_cdb_value;
    logic [ROB_IDX-1:0]  r_cdb_rob_idx;
    logic [FU_IDX-1:0]   r_cdb_src;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
        entry_t           r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_cnt;

        // Ready looks only at the count, so a same-cycle pop never opens a full FIFO.
        assign w_ready[g]    = (r_cnt != CNT_W'(FIFO_DEPTH));
        assign w_nonempty[g] = (r_cnt != '0);
        assign w_push[g]     = bus.fu_valid[g] & w_ready[g];
        assign w_pop[g]      = w_grant && (w_winner == FU_IDX'(g));
        assign w_head[g]     = r_mem[r_rptr];

        always_ff @(posedge clk) begin
            if (w_push[g])
                r_mem[r_wptr] <= '{tag:     bus.fu_tag[g*PRF_IDX +: PRF_IDX],
                                   value:   bus.fu_value[g*64 +: 64],
                                   rob_idx: bus.fu_rob_idx[g*ROB_IDX +: ROB_IDX]};
        end

        always_ff @(posedge clk) begin
            if (reset || bus.flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push[g]) r_wptr <= r_wptr + 1'b1;
                if (w_pop[g])  r_rptr <= r_rptr + 1'b1;
                case ({w_push[g], w_pop[g]})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // First non-empty source at or above rr_ptr, wrapping; pushes of this cycle are not visible yet.
    always_comb begin
        int idx;
        idx      = 0;
        w_grant  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!w_grant && w_nonempty[FU_IDX'(idx)]) begin
                w_grant  = 1'b1;
                w_winner = FU_IDX'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_cdb_valid   <= 1'b0;
            r_cdb_tag     <= '0;
            r_cdb_value   <= '0;
            r_cdb_rob_idx <= '0;
            r_cdb_src     <= '0;
        end else if (bus.flush) begin
            r_cdb_valid <= 1'b0;
        end else begin
            r_cdb_valid <= w_grant;
            if (w_grant) begin
                r_rr_ptr      <= (w_winner == FU_IDX'(NUM_FU - 1)) ? '0 : w_winner + 1'b1;
                r_cdb_tag     <= w_head[w_winner].tag;
                r_cdb_value   <= w_head[w_winner].value;
                r_cdb_rob_idx <= w_head[w_winner].rob_idx;
                r_cdb_src     <= w_winner;
            end
        end
    end

    assign bus.fu_ready    = w_ready;
    assign bus.cdb_valid   = r_cdb_valid;
    assign bus.cdb_tag     = r_cdb_tag;
    assign bus.cdb_value   = r_cdb_value;
    assign bus.cdb_rob_idx = r_cdb_rob_idx;
    assign bus.cdb_src     = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table for the simple
// paths, then hand-written sequences for contention, flush and wrap-around.
module tb_cdb_arbiter;
    localparam int NUM_FU  = 4;
    localparam int PRF_IDX = 6;
    localparam int ROB_IDX = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(4), .FU_IDX(2), .PRF_IDX(6), .ROB_IDX(5)) bus ();

    cdb_arbiter #(.NUM_FU(4), .FU_IDX(2), .FIFO_DEPTH(2), .PRF_IDX(6), .ROB_IDX(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [23:0] tags;
        logic [63:0] val;
        logic [4:0]  rob;
        logic        e_vld;
        logic [5:0]  e_tag;
        logic [63:0] e_val;
        logic [4:0]  e_rob;
        logic [1:0]  e_src;
        logic [3:0]  e_rdy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    logic [5:0] mq [4][$];

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [23:0] tags, logic [63:0] val,
                                logic [4:0] rob, logic ev, logic [5:0] et, logic [63:0] evl,
                                logic [4:0] er, logic [1:0] es, logic [3:0] erd);
        vec_t r;
        r.rst = rst; r.v = v; r.tags = tags; r.val = val; r.rob = rob;
        r.e_vld = ev; r.e_tag = et; r.e_val = evl; r.e_rob = er; r.e_src = es; r.e_rdy = erd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [23:0] tags,
                         input logic [63:0] val, input logic [4:0] rob);
        bus.fu_valid = v;
        for (int i = 0; i < NUM_FU; i++) begin
            bus.fu_tag[i*PRF_IDX +: PRF_IDX]     = tags[i*6 +: 6];
            bus.fu_value[i*64 +: 64]             = val;
            bus.fu_rob_idx[i*ROB_IDX +: ROB_IDX] = rob;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] v3;
        int s0n, s2n, s3n, w2, n2, src;
        logic [3:0]  v, acc;
        logic [23:0] tg;

        bus.flush = 1'b0;
        drive(4'b0, '0, '0, '0);
        v3 = 64'h1234_5678_9ABC_DEF0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_valid", bus.cdb_valid, 0);
        chk("rst_tag",   bus.cdb_tag, 0);
        chk("rst_value", bus.cdb_value, 0);
        chk("rst_rob",   bus.cdb_rob_idx, 0);
        chk("rst_src",   bus.cdb_src, 0);
        chk("rst_ready", bus.fu_ready, 4'b1111);
        reset = 1'b0;

        // Idle, single result latency, one-cycle burst from all four sources
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 4'b0, '0, '0, '0, 0, 0, 0, 0, 0, 4'hF));
        vecs.push_back(mk(0, 4'b0010, {6'd0, 6'd0, 6'd17, 6'd0}, 64'hDEAD_BEEF, 5'd3,
                          0, 0, 0, 0, 0, 4'hF));
        vecs.push_back(mk(0, 4'b0, '0, '0, '0, 1, 6'd17, 64'hDEAD_BEEF, 5'd3, 2'd1, 4'hF));
        vecs.push_back(mk(0, 4'b0, '0, '0, '0, 0, 6'd17, 64'hDEAD_BEEF, 5'd3, 2'd1, 4'hF));
        vecs.push_back(mk(1, 4'b0, '0, '0, '0, 0, 0, 0, 0, 0, 4'hF));
        vecs.push_back(mk(0, 4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, v3, 5'd7,
                          0, 0, 0, 0, 0, 4'hF));
        vecs.push_back(mk(0, 4'b0, '0, '0, '0, 1, 6'd10, v3, 5'd7, 2'd0, 4'hF));
        vecs.push_back(mk(0, 4'b0, '0, '0, '0, 1, 6'd11, v3, 5'd7, 2'd1, 4'hF));
        vecs.push_back(mk(0, 4'b0, '0, '0, '0, 1, 6'd12, v3, 5'd7, 2'd2, 4'hF));
        vecs.push_back(mk(0, 4'b0, '0, '0, '0, 1, 6'd13, v3, 5'd7, 2'd3, 4'hF));
        vecs.push_back(mk(0, 4'b0, '0, '0, '0, 0, 6'd13, v3, 5'd7, 2'd3, 4'hF));

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].v, vecs[i].tags, vecs[i].val, vecs[i].rob);
            tick();
            chk($sformatf("vec%0d_valid", i), bus.cdb_valid,   vecs[i].e_vld);
            chk($sformatf("vec%0d_tag", i),   bus.cdb_tag,     vecs[i].e_tag);
            chk($sformatf("vec%0d_value", i), bus.cdb_value,   vecs[i].e_val);
            chk($sformatf("vec%0d_rob", i),   bus.cdb_rob_idx, vecs[i].e_rob);
            chk($sformatf("vec%0d_src", i),   bus.cdb_src,     vecs[i].e_src);
            chk($sformatf("vec%0d_ready", i), bus.fu_ready,    vecs[i].e_rdy);
        end
        reset = 1'b0;

        // Contention: source 2 sends 20..24 while sources 0 and 3 stream continuously
        s0n = 32; s2n = 20; s3n = 48; w2 = 0; n2 = 0;
        for (int c = 0; c < 40; c++) begin
            v = '0;
            v[0] = (c < 30);
            v[2] = (s2n < 25);
            v[3] = (c < 30);
            tg = '0;
            tg[0  +: 6] = 6'(s0n);
            tg[12 +: 6] = 6'(s2n);
            tg[18 +: 6] = 6'(s3n);
            drive(v, tg, 64'h0, 5'd0);
            if (c == 2) chk("t4_ready_full", bus.fu_ready, 4'b0011);
            acc = v & bus.fu_ready;
            tick();
            if (bus.cdb_valid) begin
                src = int'(bus.cdb_src);
                if (mq[src].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL t4_unexpected: src %0d tag %0d with nothing pending", src, bus.cdb_tag);
                end else begin
                    chk($sformatf("t4_order_src%0d", src), bus.cdb_tag, mq[src].pop_front());
                end
                if (src == 2) n2++;
            end
            if (bus.cdb_valid && bus.cdb_src == 2'd2) begin
                w2 = 0;
            end else if (mq[2].size() > 0) begin
                w2++;
                chk("t4_src2_wait_le3", (w2 <= 3), 1);
            end
            if (acc[0]) begin mq[0].push_back(6'(s0n)); s0n++; end
            if (acc[2]) begin mq[2].push_back(6'(s2n)); s2n++; end
            if (acc[3]) begin mq[3].push_back(6'(s3n)); s3n++; end
        end
        chk("t4_src2_all_accepted", s2n, 25);
        chk("t4_src2_broadcasts", n2, 5);
        chk("t4_nothing_lost", mq[0].size() + mq[2].size() + mq[3].size(), 0);
        chk("t4_idle_after", bus.cdb_valid, 0);

        // Flush while a broadcast is live, with a push in the flush cycle
        drive(4'b0011, {6'd0, 6'd0, 6'd51, 6'd50}, 64'h5, 5'd1);
        tick();
        drive(4'b0011, {6'd0, 6'd0, 6'd53, 6'd52}, 64'h5, 5'd1);
        tick();
        chk("t5_valid_before_flush", bus.cdb_valid, 1);
        bus.flush = 1'b1;
        drive(4'b0100, {6'd0, 6'd60, 6'd0, 6'd0}, 64'h6, 5'd2);
        tick();
        bus.flush = 1'b0;
        drive(4'b0, '0, '0, '0);
        chk("t5_valid_after_flush", bus.cdb_valid, 0);
        chk("t5_ready_after_flush", bus.fu_ready, 4'b1111);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t5_quiet%0d_valid", i), bus.cdb_valid, 0);
            chk($sformatf("t5_quiet%0d_ready", i), bus.fu_ready, 4'b1111);
        end

        // Wrap-around: grant 2 moves rr_ptr to 3, so 3 beats 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(4'b0100, {6'd0, 6'd21, 6'd0, 6'd0}, 64'h7, 5'd4);
        tick();
        chk("t6_a_valid", bus.cdb_valid, 0);
        drive(4'b1001, {6'd43, 6'd0, 6'd0, 6'd40}, 64'h7, 5'd4);
        tick();
        drive(4'b0, '0, '0, '0);
        chk("t6_b_valid", bus.cdb_valid, 1);
        chk("t6_b_tag", bus.cdb_tag, 21);
        chk("t6_b_src", bus.cdb_src, 2);
        tick();
        chk("t6_c_valid", bus.cdb_valid, 1);
        chk("t6_c_tag", bus.cdb_tag, 43);
        chk("t6_c_src", bus.cdb_src, 3);
        tick();
        chk("t6_d_valid", bus.cdb_valid, 1);
        chk("t6_d_tag", bus.cdb_tag, 40);
        chk("t6_d_src", bus.cdb_src, 0);
        tick();
        chk("t6_e_valid", bus.cdb_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
